button_event_arbiter: RTL

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 15 +
 rtl/button_event_arbiter_btn_fsm.sv | 73 +++++++
 rtl/button_event_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared encodings for debounced button handling: per-button FSM states and
// the press/release event kind values presented to consumers.
package button_event_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PRESSED  = 2'b01,
    ST_HELD     = 2'b11,
    ST_RELEASED = 2'b10
  } btnState_t;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

endpackage

// File: rtl/button_event_arbiter_btn_fsm.sv
// One debounced button: tick-driven state machine, toggle level, and one-deep
// press/release pending flags that report an overflow when a set is lost.
module btn_fsm
  import button_event_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  input  logic i_clrPress,
  input  logic i_clrRel,
  output logic o_pressPend,
  output logic o_relPend,
  output logic o_toggle,
  output logic o_ovfSet
);

  btnState_t r_state;
  logic      r_pressPend;
  logic      r_relPend;
  logic      r_toggle;
  logic      w_setPress;
  logic      w_setRel;

  always_comb begin
    w_setPress = 1'b0;
    w_setRel   = 1'b0;
    if (i_tick) begin
      w_setPress = (r_state == ST_PRESSED) && i_btn;
      w_setRel   = (r_state == ST_HELD) && !i_btn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_toggle <= 1'b0;
    end else if (i_tick) begin
      case (r_state)
        ST_IDLE:     if (i_btn) r_state <= ST_PRESSED;
        ST_PRESSED:  r_state <= i_btn ? ST_HELD : ST_IDLE;
        ST_HELD: begin
          if (!i_btn) begin
            r_state  <= ST_RELEASED;
            r_toggle <= ~r_toggle;
          end
        end
        ST_RELEASED: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  // A set beats a same-cycle grant-clear so the newer event is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pressPend <= 1'b0;
      r_relPend   <= 1'b0;
    end else begin
      if (w_setPress)      r_pressPend <= 1'b1;
      else if (i_clrPress) r_pressPend <= 1'b0;
      if (w_setRel)        r_relPend <= 1'b1;
      else if (i_clrRel)   r_relPend <= 1'b0;
    end
  end

  assign o_ovfSet    = (w_setPress && r_pressPend && !i_clrPress) ||
                       (w_setRel && r_relPend && !i_clrRel);
  assign o_pressPend = r_pressPend;
  assign o_relPend   = r_relPend;
  assign o_toggle    = r_toggle;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces N_BTN buttons on a divided sample tick and serialises their
// press/release events through a round-robin arbiter into a valid/ready port.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter  int N_BTN    = 4,
  parameter  int TICK_DIV = 6,
  localparam int ID_W     = $clog2(N_BTN),
  localparam int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_kind,
  output logic [N_BTN-1:0] toggle,
  output logic [N_BTN-1:0] ovf,
  input  logic             clr_ovf
);

  logic [CNT_W-1:0] r_tickCnt;
  logic             w_tick;
  logic [N_BTN-1:0] w_pressPend;
  logic [N_BTN-1:0] w_relPend;
  logic [N_BTN-1:0] w_ovfSet;
  logic [N_BTN-1:0] w_clrPress;
  logic [N_BTN-1:0] w_clrRel;
  logic [N_BTN-1:0] r_ovf;
  logic [ID_W-1:0]  r_rrPtr;
  logic [ID_W-1:0]  r_evtId;
  logic             r_evtValid;
  logic             r_evtKind;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_grantId;
  logic             w_grantKind;
  logic             w_found;
  logic             w_load;
  logic             w_grant;

  assign w_tick = (r_tickCnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tickCnt <= '0;
    else if (w_tick) r_tickCnt <= '0;
    else             r_tickCnt <= r_tickCnt + 1'b1;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (w_tick),
      .i_btn       (btn[gi]),
      .i_clrPress  (w_clrPress[gi]),
      .i_clrRel    (w_clrRel[gi]),
      .o_pressPend (w_pressPend[gi]),
      .o_relPend   (w_relPend[gi]),
      .o_toggle    (toggle[gi]),
      .o_ovfSet    (w_ovfSet[gi])
    );
  end

  // Scan downward from the farthest slot so the last hit is the one nearest rr_ptr.
  always_comb begin
    w_found     = 1'b0;
    w_grantId   = '0;
    w_grantKind = EVT_RELEASE;
    w_idx       = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_rrPtr) + k) % N_BTN);
      if (w_pressPend[w_idx] || w_relPend[w_idx]) begin
        w_found     = 1'b1;
        w_grantId   = w_idx;
        w_grantKind = w_pressPend[w_idx] ? EVT_PRESS : EVT_RELEASE;
      end
    end
  end

  assign w_load  = !r_evtValid || evt_ready;
  assign w_grant = w_load && w_found;

  always_comb begin
    w_clrPress = '0;
    w_clrRel   = '0;
    if (w_grant) begin
      if (w_grantKind == EVT_PRESS) w_clrPress[w_grantId] = 1'b1;
      else                          w_clrRel[w_grantId]   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evtValid <= 1'b0;
      r_evtId    <= '0;
      r_evtKind  <= EVT_RELEASE;
      r_rrPtr    <= '0;
    end else if (w_load) begin
      r_evtValid <= w_found;
      if (w_found) begin
        r_evtId   <= w_grantId;
        r_evtKind <= w_grantKind;
        r_rrPtr   <= (w_grantId == ID_W'(N_BTN - 1)) ? '0 : w_grantId + 1'b1;
      end
    end
  end

  // A fresh overflow in the same cycle as clr_ovf must survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovf <= '0;
    else     r_ovf <= (clr_ovf ? '0 : r_ovf) | w_ovfSet;
  end

  assign evt_valid = r_evtValid;
  assign evt_id    = r_evtId;
  assign evt_kind  = r_evtKind;
  assign ovf       = r_ovf;

endmodule
